// File: rtl/mist_ctrl_spi_master.sv
// IO-controller side of the user_io SPI protocol: watches the button, switch, joystick
// and status inputs and sends a command frame for each word that changed since it was last sent.
module mist_ctrl_spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        sys_reset,
    input  logic [1:0]  buttons_in,
    input  logic        scandoubler_disable_in,
    input  logic [19:0] joystick_0_in,
    input  logic [19:0] joystick_1_in,
    input  logic [31:0] status_in,
    output logic        SPI_SCK,
    output logic        SPI_DI,
    output logic        CONF_DATA0,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SCK_HI, S_SCK_LO, S_HOLD, S_GAP
    } state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_div;
    logic        r_gap_half;
    logic [5:0]  r_bits;
    logic [39:0] r_shift;
    logic [2:0]  r_btn_sent;
    logic [19:0] r_joy0_sent, r_joy1_sent;
    logic [31:0] r_status_sent;
    logic [3:0]  r_pending;     // {STATUS, JOY1, JOY0, BTN}

    logic [2:0]  w_btn_live;
    logic [3:0]  w_changed;
    logic [3:0]  w_grant;
    logic        w_sel;
    logic        w_div_done;
    logic        w_reload;
    logic [39:0] w_load_data;
    logic [5:0]  w_load_bits;

    assign w_btn_live = {scandoubler_disable_in, buttons_in};
    assign w_changed  = {status_in != r_status_sent, joystick_1_in != r_joy1_sent,
                         joystick_0_in != r_joy0_sent, w_btn_live != r_btn_sent};
    assign w_sel      = (r_state == S_IDLE) && (|r_pending);
    assign w_div_done = (r_div == 8'd0);
    // GAP spans two divider periods so the 8-bit divider never has to hold 2*CLK_DIV.
    assign w_reload   = (w_state_nxt != r_state) || (r_state == S_GAP && w_div_done);

    always_comb begin
        w_grant = 4'b0000;
        if (w_sel) begin
            if (r_pending[0])      w_grant = 4'b0001;
            else if (r_pending[1]) w_grant = 4'b0010;
            else if (r_pending[2]) w_grant = 4'b0100;
            else                   w_grant = 4'b1000;
        end
    end

    // Frames are left-aligned so the shifter always sends from bit 39.
    always_comb begin
        w_load_data = {8'h1E, status_in[7:0], status_in[15:8], status_in[23:16], status_in[31:24]};
        w_load_bits = 6'd40;
        if (w_grant[0]) begin
            w_load_data = {8'h01, 3'b000, scandoubler_disable_in, 2'b00, buttons_in, 24'h000000};
            w_load_bits = 6'd16;
        end else if (w_grant[1]) begin
            w_load_data = {8'h02, joystick_0_in[7:0], joystick_0_in[15:8], 4'h0, joystick_0_in[19:16], 8'h00};
        end else if (w_grant[2]) begin
            w_load_data = {8'h03, joystick_1_in[7:0], joystick_1_in[15:8], 4'h0, joystick_1_in[19:16], 8'h00};
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_reset) begin
            r_pending     <= 4'hF;
            r_btn_sent    <= '0;
            r_joy0_sent   <= '0;
            r_joy1_sent   <= '0;
            r_status_sent <= '0;
        end else begin
            r_pending <= (r_pending | w_changed) & ~w_grant;
            if (w_grant[0]) r_btn_sent    <= w_btn_live;
            if (w_grant[1]) r_joy0_sent   <= joystick_0_in;
            if (w_grant[2]) r_joy1_sent   <= joystick_1_in;
            if (w_grant[3]) r_status_sent <= status_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_sel) begin
            r_shift <= w_load_data;
            r_bits  <= w_load_bits;
        end else if (r_state == S_SCK_HI && w_div_done) begin
            r_shift <= {r_shift[38:0], 1'b0};
            r_bits  <= r_bits - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_reset) begin
            r_div      <= DIV_RELOAD;
            r_gap_half <= 1'b0;
        end else begin
            if (w_reload)            r_div <= DIV_RELOAD;
            else if (!w_div_done)    r_div <= r_div - 8'd1;
            r_gap_half <= (r_state == S_GAP) ? (r_gap_half | w_div_done) : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_reset) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (|r_pending)  w_state_nxt = S_SETUP;
            S_SETUP:  if (w_div_done)  w_state_nxt = S_SCK_HI;
            S_SCK_HI: if (w_div_done)  w_state_nxt = S_SCK_LO;
            S_SCK_LO: if (w_div_done)  w_state_nxt = (r_bits == 6'd0) ? S_HOLD : S_SCK_HI;
            S_HOLD:   if (w_div_done)  w_state_nxt = S_GAP;
            S_GAP:    if (w_div_done && r_gap_half) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        CONF_DATA0 = !(r_state == S_SETUP || r_state == S_SCK_HI || r_state == S_SCK_LO);
        SPI_SCK    = (r_state == S_SCK_HI);
        SPI_DI     = !CONF_DATA0 && r_shift[39];
        busy       = (r_state != S_IDLE);
        frame_done = (r_state == S_HOLD) && (r_div == DIV_RELOAD);
    end

endmodule

// File: tb/tb_mist_ctrl_spi_master.sv
// Bench for mist_ctrl_spi_master: a slave model decodes each frame on SCK rising edges
// and records its bits, data and select-low time for comparison with hand-computed frames.
module tb_mist_ctrl_spi_master;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        sys_reset;
    logic [1:0]  buttons_in;
    logic        scandoubler_disable_in;
    logic [19:0] joystick_0_in, joystick_1_in;
    logic [31:0] status_in;
    logic        SPI_SCK, SPI_DI, CONF_DATA0, busy, frame_done;

    always #5 clk = ~clk;

    mist_ctrl_spi_master #(.CLK_DIV(D)) dut (
        .clk(clk), .sys_reset(sys_reset), .buttons_in(buttons_in),
        .scandoubler_disable_in(scandoubler_disable_in),
        .joystick_0_in(joystick_0_in), .joystick_1_in(joystick_1_in),
        .status_in(status_in), .SPI_SCK(SPI_SCK), .SPI_DI(SPI_DI),
        .CONF_DATA0(CONF_DATA0), .busy(busy), .frame_done(frame_done)
    );

    typedef struct {
        int          nbits;
        logic [39:0] data;
        int          low;
    } frame_t;

    typedef struct {
        logic [1:0]  btn;
        logic        sd;
        logic [19:0] j0;
        logic [19:0] j1;
        logic [31:0] st;
        int          nbits;
        logic [39:0] data;
    } vec_t;

    frame_t      q[$];
    vec_t        vt[8];
    int          total = 0;
    int          bad = 0;
    int          fd_cnt = 0;
    int          viol_cnt = 0;
    int          mon_bits = 0;
    int          mon_low = 0;
    logic [39:0] mon_rx = '0;
    logic        prev_ss = 1'b1, prev_sck = 1'b0, prev_di = 1'b0;

    // Slave model
    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (CONF_DATA0 && SPI_DI) viol_cnt++;
            if (SPI_SCK && prev_sck && (SPI_DI != prev_di)) viol_cnt++;
            if (!CONF_DATA0) begin
                if (prev_ss) begin
                    mon_low = 0; mon_bits = 0; mon_rx = '0;
                end
                mon_low++;
                if (SPI_SCK && !prev_sck) begin
                    mon_rx = {mon_rx[38:0], SPI_DI};
                    mon_bits++;
                end
            end else if (!prev_ss) begin
                f.nbits = mon_bits; f.data = mon_rx; f.low = mon_low;
                q.push_back(f);
            end
            prev_ss = CONF_DATA0; prev_sck = SPI_SCK; prev_di = SPI_DI;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input string name, input int nbits, input logic [39:0] data,
                                output frame_t f);
        int n = 0;
        f.nbits = 0; f.data = '0; f.low = 0;
        while (q.size() == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: actual=no frame required=frame within 3000 cycles", name);
        end else begin
            f = q.pop_front();
            check({name, "_bits"}, 64'(f.nbits), 64'(nbits));
            check({name, "_data"}, {24'h0, f.data}, {24'h0, data});
            check({name, "_low"}, 64'(f.low), 64'(D * (2 * nbits + 1)));
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (10) @(posedge clk);
        check({name, "_idle_busy"}, {63'h0, busy}, 64'h0);
        check({name, "_no_extra_frames"}, 64'(q.size()), 64'h0);
    endtask

    task automatic set_in(input logic [1:0] btn, input logic sd, input logic [19:0] j0,
                          input logic [19:0] j1, input logic [31:0] st);
        @(posedge clk);
        #1;
        buttons_in = btn; scandoubler_disable_in = sd;
        joystick_0_in = j0; joystick_1_in = j1; status_in = st;
    endtask

    initial begin
        frame_t f;
        int     act;
        int     n;

        vt[0] = '{2'b10, 1'b0, 20'h00010, 20'h00000, 32'h0000_0030, 40, 40'h1E_30_00_00_00};
        vt[1] = '{2'b01, 1'b0, 20'h00010, 20'h00000, 32'h0000_0030, 16, 40'h00_00_00_01_01};
        vt[2] = '{2'b01, 1'b1, 20'h00010, 20'h00000, 32'h0000_0030, 16, 40'h00_00_00_01_11};
        vt[3] = '{2'b01, 1'b1, 20'hABCDE, 20'h00000, 32'h0000_0030, 40, 40'h02_DE_BC_0A_00};
        vt[4] = '{2'b01, 1'b1, 20'hABCDE, 20'h12345, 32'h0000_0030, 40, 40'h03_45_23_01_00};
        vt[5] = '{2'b01, 1'b1, 20'hABCDE, 20'h12345, 32'hDEAD_BEEF, 40, 40'h1E_EF_BE_AD_DE};
        vt[6] = '{2'b10, 1'b1, 20'hABCDE, 20'h12345, 32'hDEAD_BEEF, 16, 40'h00_00_00_01_12};
        vt[7] = '{2'b10, 1'b1, 20'hFFFFF, 20'h12345, 32'hDEAD_BEEF, 40, 40'h02_FF_FF_0F_00};

        sys_reset = 1'b0;
        buttons_in = '0; scandoubler_disable_in = 1'b0;
        joystick_0_in = '0; joystick_1_in = '0; status_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {59'h0, SPI_SCK, SPI_DI, CONF_DATA0, busy, frame_done}, 64'b00100);
        @(posedge clk);
        #1 sys_reset = 1'b1;

        expect_frame("rst_btn",    16, 40'h00_00_00_01_00, f);
        expect_frame("rst_joy0",   40, 40'h02_00_00_00_00, f);
        expect_frame("rst_joy1",   40, 40'h03_00_00_00_00, f);
        expect_frame("rst_status", 40, 40'h1E_00_00_00_00, f);
        wait_idle("rst_seq");
        check("rst_frame_done_pulses", 64'(fd_cnt), 64'd4);

        act = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!CONF_DATA0 || busy) act++;
        end
        check("idle_quiet_cycles", 64'(act), 64'd0);
        check("idle_no_frames", 64'(q.size()), 64'd0);

        set_in(2'b10, 1'b0, 20'h00010, 20'h00000, 32'h0);
        expect_frame("simul_btn_first", 16, 40'h00_00_00_01_02, f);
        expect_frame("simul_joy0_second", 40, 40'h02_10_00_00_00, f);
        wait_idle("simul");

        for (int i = 0; i < 8; i++) begin
            set_in(vt[i].btn, vt[i].sd, vt[i].j0, vt[i].j1, vt[i].st);
            expect_frame($sformatf("vec%0d", i), vt[i].nbits, vt[i].data, f);
            if (i == 0) check("slave_status_5_4", {62'h0, f.data[29:28]}, 64'b11);
            wait_idle($sformatf("vec%0d", i));
        end

        set_in(2'b00, 1'b1, 20'hFFFFF, 20'h12345, 32'hDEAD_BEEF);
        expect_frame("btn_clear", 16, 40'h00_00_00_01_10, f);
        wait_idle("btn_clear");
        set_in(2'b00, 1'b1, 20'hFFFFF, 20'h12345, 32'h0000_0001);
        n = 0;
        while (CONF_DATA0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (80) @(posedge clk);
        check("mid_status_ss_low", {63'h0, CONF_DATA0}, 64'h0);
        #1 buttons_in = 2'b01;
        expect_frame("mid_status_frame", 40, 40'h1E_01_00_00_00, f);
        expect_frame("mid_status_btn_after", 16, 40'h00_00_00_01_11, f);
        wait_idle("mid_status");

        set_in(2'b01, 1'b1, 20'hFFFFF, 20'h54321, 32'h0000_0001);
        n = 0;
        while (!(!CONF_DATA0 && mon_bits >= 20) && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("joy1_reached_bit20", 64'(mon_bits), 64'd20);
        #1 sys_reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_outputs", {60'h0, CONF_DATA0, SPI_SCK, SPI_DI, busy}, 64'b1000);
        repeat (3) @(posedge clk);
        #1;
        q.delete();
        fd_cnt = 0;
        sys_reset = 1'b1;
        expect_frame("rerst_btn",    16, 40'h00_00_00_01_11, f);
        expect_frame("rerst_joy0",   40, 40'h02_FF_FF_0F_00, f);
        expect_frame("rerst_joy1",   40, 40'h03_21_43_05_00, f);
        expect_frame("rerst_status", 40, 40'h1E_01_00_00_00, f);
        wait_idle("rerst_seq");
        check("rerst_frame_done_pulses", 64'(fd_cnt), 64'd4);

        check("di_protocol_violations", 64'(viol_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
